// File: rtl/fetch_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_seq_ctrl_if
// Bundle of the fetch-sequencing signals exchanged between the pipeline and
// the fetch sequencing controller.
//
//   Pipeline -> controller:
//     ins[23:0]              instruction presented by the PCIM fetch stage
//     ex_branch_taken        execute stage resolved a taken branch
//     ex_branch_target[7:0]  target of that branch
//     ext_hold               multi-cycle unit busy, freeze fetch
//   Controller -> pipeline:
//     pc_mux_sel             1 = PC loads jmp_loc at the next edge
//     jmp_loc[7:0]           redirect address (0 when not redirecting)
//     Stall / Stall_pm       freeze PC / instruction-memory output register
//     flush                  squash the IF/ID instruction
//     bubble                 insert a NOP into ID/EX
//     ctrl_state[1:0]        FSM state (RUN=0, FLUSH=1, LU=2, HOLD=3)
//     stall_cnt[15:0]        saturating count of stalled cycles
//
// master = pipeline side, slave = controller side.
// ---------------------------------------------------------------------------
interface fetch_seq_ctrl_if;
   logic [23:0] ins;
   logic        ex_branch_taken;
   logic [7:0]  ex_branch_target;
   logic        ext_hold;
   logic        pc_mux_sel;
   logic [7:0]  jmp_loc;
   logic        Stall;
   logic        Stall_pm;
   logic        flush;
   logic        bubble;
   logic [1:0]  ctrl_state;
   logic [15:0] stall_cnt;

   modport master (
      output ins, ex_branch_taken, ex_branch_target, ext_hold,
      input  pc_mux_sel, jmp_loc, Stall, Stall_pm, flush, bubble,
             ctrl_state, stall_cnt
   );

   modport slave (
      input  ins, ex_branch_taken, ex_branch_target, ext_hold,
      output pc_mux_sel, jmp_loc, Stall, Stall_pm, flush, bubble,
             ctrl_state, stall_cnt
   );
endinterface

// File: rtl/fetch_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_seq_ctrl
// Fetch sequencing controller: decides every cycle whether the PC advances
// sequentially, is redirected (taken branch or JMP), or is frozen (external
// hold or load-use hazard), and produces the matching flush/bubble controls.
//
// Ports:
//   clk    single clock, all state updates on its rising edge
//   reset  asynchronous, active-high; clears all state and forces all
//          outputs to 0 while asserted
//   bus    fetch_seq_ctrl_if.slave (see interface header for signal list)
//
// Registered: FSM state, pending branch (flag + target), load tracker
// (prev_ld, prev_rd) and stall_cnt. Every other output is combinational
// from those registers and the current inputs.
//
// Per-cycle priority: reset > ext_hold > branch (live or pending) >
// JMP decode > load-use.
// ---------------------------------------------------------------------------
module fetch_seq_ctrl #(
   parameter logic [4:0] OP_JMP = 5'b11000,
   parameter logic [4:0] OP_LD  = 5'b10100
) (
   input logic               clk,
   input logic               reset,
   fetch_seq_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_LU    = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   // Instruction field extraction
   function automatic logic [4:0] f_opcode(input logic [23:0] i);
      f_opcode = i[23:19];
   endfunction

   function automatic logic [4:0] f_rd(input logic [23:0] i);
      f_rd = i[18:14];
   endfunction

   // Load-use hazard: preceding load writes a non-zero register that the
   // current instruction reads through rs1 or rs2.
   function automatic logic f_load_use(input logic        ld,
                                       input logic [4:0]  rd,
                                       input logic [23:0] i);
      f_load_use = ld && (rd != 5'd0) &&
                   ((rd == i[13:9]) || (rd == i[8:4]));
   endfunction

   // Registered state
   state_t      state_r;
   logic        pend_r;
   logic [7:0]  pend_tgt_r;
   logic        prev_ld_r;
   logic [4:0]  prev_rd_r;
   logic [15:0] stall_cnt_r;

   // Next-state and combinational outputs
   state_t      state_nxt_s;
   logic        pend_nxt_s;
   logic [7:0]  pend_tgt_nxt_s;
   logic        prev_ld_nxt_s;
   logic [4:0]  prev_rd_nxt_s;
   logic        pc_mux_sel_s;
   logic [7:0]  jmp_loc_s;
   logic        stall_s;
   logic        stall_pm_s;
   logic        flush_s;
   logic        bubble_s;
   logic [7:0]  branch_tgt_s;

   // A live branch is newer than anything pending, so it wins the target.
   assign branch_tgt_s = bus.ex_branch_taken ? bus.ex_branch_target : pend_tgt_r;

   // Per-cycle sequencing decision in priority order
   always_comb begin
      state_nxt_s    = ST_RUN;
      pend_nxt_s     = pend_r;
      pend_tgt_nxt_s = pend_tgt_r;
      prev_ld_nxt_s  = prev_ld_r;
      prev_rd_nxt_s  = prev_rd_r;
      pc_mux_sel_s   = 1'b0;
      jmp_loc_s      = 8'h00;
      stall_s        = 1'b0;
      stall_pm_s     = 1'b0;
      flush_s        = 1'b0;
      bubble_s       = 1'b0;

      if (reset) begin
         // Outputs stay 0 while reset is high; registers are cleared
         // asynchronously so the next-state values are irrelevant here.
         state_nxt_s = ST_RUN;
      end else if (bus.ext_hold) begin
         // Freeze fetch; a branch resolved meanwhile is parked until release.
         stall_s     = 1'b1;
         stall_pm_s  = 1'b1;
         state_nxt_s = ST_HOLD;
         if (bus.ex_branch_taken) begin
            pend_nxt_s     = 1'b1;
            pend_tgt_nxt_s = bus.ex_branch_target;
         end else begin
            pend_nxt_s = pend_r;
         end
      end else if (bus.ex_branch_taken || pend_r) begin
         // Redirect and squash the wrong-path instruction right away.
         pc_mux_sel_s  = 1'b1;
         jmp_loc_s     = branch_tgt_s;
         flush_s       = 1'b1;
         pend_nxt_s    = 1'b0;
         prev_ld_nxt_s = 1'b0;
         state_nxt_s   = ST_FLUSH;
      end else if (state_r == ST_FLUSH) begin
         // The instruction in IF/ID is on the wrong path: squash it and do
         // not decode it (no JMP, no load tracking).
         flush_s     = 1'b1;
         state_nxt_s = ST_RUN;
      end else begin
         // RUN, LU, or first cycle after HOLD: normal decode.
         if (f_opcode(bus.ins) == OP_JMP) begin
            pc_mux_sel_s  = 1'b1;
            jmp_loc_s     = bus.ins[7:0];
            prev_ld_nxt_s = 1'b0;
            prev_rd_nxt_s = f_rd(bus.ins);
            state_nxt_s   = ST_FLUSH;
         end else if (f_load_use(prev_ld_r, prev_rd_r, bus.ins)) begin
            // Clearing prev_ld keeps the held instruction from stalling twice.
            stall_s       = 1'b1;
            stall_pm_s    = 1'b1;
            bubble_s      = 1'b1;
            prev_ld_nxt_s = 1'b0;
            state_nxt_s   = ST_LU;
         end else begin
            prev_ld_nxt_s = (f_opcode(bus.ins) == OP_LD);
            prev_rd_nxt_s = f_rd(bus.ins);
            state_nxt_s   = ST_RUN;
         end
      end
   end

   // State, pending branch, load tracker and stall counter registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_RUN;
         pend_r      <= 1'b0;
         pend_tgt_r  <= 8'h00;
         prev_ld_r   <= 1'b0;
         prev_rd_r   <= 5'd0;
         stall_cnt_r <= 16'h0000;
      end else begin
         state_r    <= state_nxt_s;
         pend_r     <= pend_nxt_s;
         pend_tgt_r <= pend_tgt_nxt_s;
         prev_ld_r  <= prev_ld_nxt_s;
         prev_rd_r  <= prev_rd_nxt_s;
         if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign bus.pc_mux_sel = pc_mux_sel_s;
   assign bus.jmp_loc    = jmp_loc_s;
   assign bus.Stall      = stall_s;
   assign bus.Stall_pm   = stall_pm_s;
   assign bus.flush      = flush_s;
   assign bus.bubble     = bubble_s;
   assign bus.ctrl_state = state_r;
   assign bus.stall_cnt  = stall_cnt_r;

endmodule
